// File: rtl/timer_bus_arbiter.sv
// Round-robin arbiter that shares the Timer slave port among NUM_MASTERS requesters.
// Optional ACCESS-state timeout is compiled in when TIMER_ARB_TIMEOUT_EN is defined.

`ifndef READ
`define READ 1'b1
`endif
`ifndef WRITE
`define WRITE 1'b0
`endif

module timer_bus_arbiter #(
  parameter int NUM_MASTERS    = 4,
  parameter int OWNER_W        = 2,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                      clk,
  input  logic                      rest,
  input  logic [NUM_MASTERS-1:0]    m_req,
  input  logic [NUM_MASTERS-1:0]    m_rw,
  input  logic [NUM_MASTERS*4-1:0]  m_addr,
  input  logic [NUM_MASTERS*32-1:0] m_wr_data,
  output logic [NUM_MASTERS-1:0]    m_ack,
  output logic [NUM_MASTERS-1:0]    m_err,
  output logic [31:0]               m_rd_data,
  output logic                      busy,
  output logic [OWNER_W-1:0]        owner,
  output logic                      tmr_cs,
  output logic                      tmr_as,
  output logic                      tmr_rw,
  output logic [3:0]                tmr_addr,
  output logic [31:0]               tmr_wr_data,
  input  logic                      tmr_rdy,
  input  logic [31:0]               tmr_rd_data
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
  } state_t;

  state_t state, state_nxt;

  logic [OWNER_W-1:0] owner_q;
  logic [OWNER_W-1:0] last_grant;
  logic [OWNER_W-1:0] grant_idx;
  logic [OWNER_W-1:0] scan_idx;
  logic               grant_valid;
  logic               lat_rw;
  logic [3:0]         lat_addr;
  logic [31:0]        lat_wr_data;
  logic               timeout_hit;

  logic [3:0]  addr_arr [NUM_MASTERS];
  logic [31:0] data_arr [NUM_MASTERS];

  for (genvar i = 0; i < NUM_MASTERS; i++) begin : g_unpack
    assign addr_arr[i] = m_addr[4*i +: 4];
    assign data_arr[i] = m_wr_data[32*i +: 32];
  end

  // Scan upward from the master after last_grant so the previous winner goes last.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    scan_idx    = '0;
    for (int k = 1; k <= NUM_MASTERS; k++) begin
      scan_idx = OWNER_W'((int'(last_grant) + k) % NUM_MASTERS);
      if (!grant_valid && m_req[scan_idx]) begin
        grant_valid = 1'b1;
        grant_idx   = scan_idx;
      end
    end
  end

`ifdef TIMER_ARB_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TO_W-1:0] to_cnt;
  logic            err_q;

  // Fires on the edge where the counter would reach TIMEOUT_CYCLES; rdy takes precedence.
  assign timeout_hit = (state == ACCESS) && !tmr_rdy &&
                       (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge rest) begin
    if (rest) begin
      to_cnt <= '0;
      err_q  <= 1'b0;
    end else if (state == IDLE && grant_valid) begin
      to_cnt <= '0;
      err_q  <= 1'b0;
    end else if (state == ACCESS && !tmr_rdy) begin
      to_cnt <= to_cnt + TO_W'(1);
      if (timeout_hit) begin
        err_q <= 1'b1;
      end
    end
  end
`else
  logic [31:0] unused_timeout_cfg;
  assign unused_timeout_cfg = 32'(TIMEOUT_CYCLES);
  assign timeout_hit        = 1'b0;
`endif

  always_ff @(posedge clk or posedge rest) begin
    if (rest) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (grant_valid) begin
          state_nxt = ACCESS;
        end
      end
      ACCESS: begin
        if (tmr_rdy || timeout_hit) begin
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Latched request copy drives the Timer so late master-side changes cannot leak through.
  always_ff @(posedge clk or posedge rest) begin
    if (rest) begin
      owner_q     <= '0;
      last_grant  <= OWNER_W'(NUM_MASTERS - 1);
      lat_rw      <= 1'b0;
      lat_addr    <= '0;
      lat_wr_data <= '0;
      m_rd_data   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_valid) begin
            owner_q     <= grant_idx;
            lat_rw      <= m_rw[grant_idx];
            lat_addr    <= addr_arr[grant_idx];
            lat_wr_data <= data_arr[grant_idx];
          end
        end
        ACCESS: begin
          if (tmr_rdy) begin
            if (lat_rw == `READ) begin
              m_rd_data <= tmr_rd_data;
            end
          end else if (timeout_hit) begin
            m_rd_data <= '0;
          end
        end
        DONE: begin
          last_grant <= owner_q;
        end
        default: begin
        end
      endcase
    end
  end

  always_comb begin
    m_ack = '0;
    m_err = '0;
    if (state == DONE) begin
      m_ack[owner_q] = 1'b1;
`ifdef TIMER_ARB_TIMEOUT_EN
      m_err[owner_q] = err_q;
`endif
    end
  end

  assign busy        = (state != IDLE);
  assign owner       = owner_q;
  assign tmr_cs      = (state == ACCESS);
  assign tmr_as      = (state == ACCESS);
  assign tmr_rw      = lat_rw;
  assign tmr_addr    = lat_addr;
  assign tmr_wr_data = lat_wr_data;

endmodule

// File: tb/tb_timer_bus_arbiter.sv
// Directed testbench for timer_bus_arbiter with a registered-ready Timer model.
// Timeout scenario is included when TIMER_ARB_TIMEOUT_EN is defined.

`ifndef READ
`define READ 1'b1
`endif
`ifndef WRITE
`define WRITE 1'b0
`endif

module tb_timer_bus_arbiter;

  localparam int NM = 4;
  localparam logic [3:0] EXPR      = 4'h3;
  localparam logic [3:0] CTRL_ADDR = 4'h1;

  logic           clk;
  logic           rest;
  logic [NM-1:0]  m_req;
  logic [NM-1:0]  m_rw;
  logic [NM*4-1:0]  m_addr;
  logic [NM*32-1:0] m_wr_data;
  logic [NM-1:0]  m_ack;
  logic [NM-1:0]  m_err;
  logic [31:0]    m_rd_data;
  logic           busy;
  logic [1:0]     owner;
  logic           tmr_cs;
  logic           tmr_as;
  logic           tmr_rw;
  logic [3:0]     tmr_addr;
  logic [31:0]    tmr_wr_data;
  logic           tmr_rdy;
  logic [31:0]    tmr_rd_data;

  logic           timer_en;
  int             checks;
  int             errors;

  timer_bus_arbiter #(
    .NUM_MASTERS(NM),
    .OWNER_W(2),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk),
    .rest(rest),
    .m_req(m_req),
    .m_rw(m_rw),
    .m_addr(m_addr),
    .m_wr_data(m_wr_data),
    .m_ack(m_ack),
    .m_err(m_err),
    .m_rd_data(m_rd_data),
    .busy(busy),
    .owner(owner),
    .tmr_cs(tmr_cs),
    .tmr_as(tmr_as),
    .tmr_rw(tmr_rw),
    .tmr_addr(tmr_addr),
    .tmr_wr_data(tmr_wr_data),
    .tmr_rdy(tmr_rdy),
    .tmr_rd_data(tmr_rd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Timer model: ready is registered, high the cycle after cs&as is sampled.
  always @(posedge clk or posedge rest) begin
    if (rest) begin
      tmr_rdy <= 1'b0;
    end else begin
      tmr_rdy <= timer_en & tmr_cs & tmr_as;
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired at %0t", $time);
    $fatal(1, "[TB] watchdog");
  end

  task automatic do_reset;
    rest  = 1'b1;
    m_req = '0;
    @(negedge clk);
    @(negedge clk);
    rest = 1'b0;
  endtask

  task automatic test_reset;
    rest = 1'b1;
    @(negedge clk);
    checks++; if (m_ack !== 4'b0) begin errors++; $display("[TB] FAIL rst_ack got %b exp 0000", m_ack); end
    checks++; if (m_err !== 4'b0) begin errors++; $display("[TB] FAIL rst_err got %b exp 0000", m_err); end
    checks++; if (m_rd_data !== 32'h0) begin errors++; $display("[TB] FAIL rst_rd_data got %h exp 0", m_rd_data); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL rst_busy got %b exp 0", busy); end
    checks++; if (owner !== 2'd0) begin errors++; $display("[TB] FAIL rst_owner got %0d exp 0", owner); end
    checks++; if ({tmr_cs, tmr_as, tmr_rw} !== 3'b000) begin errors++; $display("[TB] FAIL rst_strobes got %b exp 000", {tmr_cs, tmr_as, tmr_rw}); end
    checks++; if (tmr_addr !== 4'h0) begin errors++; $display("[TB] FAIL rst_addr got %h exp 0", tmr_addr); end
    checks++; if (tmr_wr_data !== 32'h0) begin errors++; $display("[TB] FAIL rst_wr_data got %h exp 0", tmr_wr_data); end
    rest = 1'b0;
  endtask

  task automatic test_single_read;
    tmr_rd_data       = 32'h0000_1234;
    m_rw[1]           = `READ;
    m_addr[4 +: 4]    = EXPR;
    m_req             = 4'b0010;
    @(negedge clk);
    checks++; if ({tmr_cs, tmr_as} !== 2'b11) begin errors++; $display("[TB] FAIL rd_cs_c1 got %b exp 11", {tmr_cs, tmr_as}); end
    checks++; if (owner !== 2'd1) begin errors++; $display("[TB] FAIL rd_owner got %0d exp 1", owner); end
    checks++; if (tmr_addr !== EXPR) begin errors++; $display("[TB] FAIL rd_addr got %h exp %h", tmr_addr, EXPR); end
    checks++; if (tmr_rw !== `READ) begin errors++; $display("[TB] FAIL rd_rw got %b exp 1", tmr_rw); end
    checks++; if (m_ack !== 4'b0) begin errors++; $display("[TB] FAIL rd_ack_c1 got %b exp 0000", m_ack); end
    @(negedge clk);
    checks++; if ({tmr_cs, tmr_as} !== 2'b11) begin errors++; $display("[TB] FAIL rd_cs_c2 got %b exp 11", {tmr_cs, tmr_as}); end
    checks++; if (m_ack !== 4'b0) begin errors++; $display("[TB] FAIL rd_ack_c2 got %b exp 0000", m_ack); end
    @(negedge clk);
    checks++; if (m_ack !== 4'b0010) begin errors++; $display("[TB] FAIL rd_ack got %b exp 0010", m_ack); end
    checks++; if (m_err !== 4'b0) begin errors++; $display("[TB] FAIL rd_err got %b exp 0000", m_err); end
    checks++; if (m_rd_data !== 32'h0000_1234) begin errors++; $display("[TB] FAIL rd_data got %h exp 00001234", m_rd_data); end
    checks++; if (tmr_cs !== 1'b0) begin errors++; $display("[TB] FAIL rd_cs_done got %b exp 0", tmr_cs); end
    m_req = 4'b0;
    @(negedge clk);
    checks++; if ({busy, m_ack} !== 5'b0) begin errors++; $display("[TB] FAIL rd_idle got %b exp 00000", {busy, m_ack}); end
    checks++; if (m_rd_data !== 32'h0000_1234) begin errors++; $display("[TB] FAIL rd_hold got %h exp 00001234", m_rd_data); end
  endtask

  task automatic test_write_stability;
    m_rw[2]             = `WRITE;
    m_addr[8 +: 4]      = CTRL_ADDR;
    m_wr_data[64 +: 32] = 32'h5;
    m_req               = 4'b0100;
    @(negedge clk);
    checks++; if (owner !== 2'd2) begin errors++; $display("[TB] FAIL wr_owner got %0d exp 2", owner); end
    checks++; if (tmr_rw !== `WRITE) begin errors++; $display("[TB] FAIL wr_rw got %b exp 0", tmr_rw); end
    checks++; if (tmr_wr_data !== 32'h5) begin errors++; $display("[TB] FAIL wr_data_c1 got %h exp 5", tmr_wr_data); end
    m_req               = 4'b0101;
    m_wr_data[64 +: 32] = 32'hDEAD_BEEF;
    m_addr[8 +: 4]      = 4'hF;
    m_rw[0]             = `WRITE;
    m_addr[0 +: 4]      = 4'h4;
    m_wr_data[0 +: 32]  = 32'h9;
    @(negedge clk);
    checks++; if (tmr_wr_data !== 32'h5) begin errors++; $display("[TB] FAIL wr_data_c2 got %h exp 5", tmr_wr_data); end
    checks++; if (tmr_addr !== CTRL_ADDR) begin errors++; $display("[TB] FAIL wr_addr_c2 got %h exp %h", tmr_addr, CTRL_ADDR); end
    @(negedge clk);
    checks++; if (m_ack !== 4'b0100) begin errors++; $display("[TB] FAIL wr_ack2 got %b exp 0100", m_ack); end
    checks++; if (m_rd_data !== 32'h0000_1234) begin errors++; $display("[TB] FAIL wr_rd_kept got %h exp 00001234", m_rd_data); end
    m_req = 4'b0001;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL wr_gap_busy got %b exp 0", busy); end
    @(negedge clk);
    checks++; if (owner !== 2'd0) begin errors++; $display("[TB] FAIL wr_next_owner got %0d exp 0", owner); end
    checks++; if (tmr_wr_data !== 32'h9 || tmr_addr !== 4'h4) begin errors++; $display("[TB] FAIL wr_m0_bus got %h/%h exp 9/4", tmr_wr_data, tmr_addr); end
    @(negedge clk);
    @(negedge clk);
    checks++; if (m_ack !== 4'b0001) begin errors++; $display("[TB] FAIL wr_ack0 got %b exp 0001", m_ack); end
    m_req = 4'b0;
    @(negedge clk);
  endtask

  task automatic test_drop_request;
    tmr_rd_data      = 32'h0000_CAFE;
    m_rw[3]          = `READ;
    m_addr[12 +: 4]  = EXPR;
    m_req            = 4'b1000;
    @(negedge clk);
    checks++; if (owner !== 2'd3) begin errors++; $display("[TB] FAIL drop_owner got %0d exp 3", owner); end
    m_req = 4'b0;
    @(negedge clk);
    checks++; if (tmr_cs !== 1'b1) begin errors++; $display("[TB] FAIL drop_cs got %b exp 1", tmr_cs); end
    @(negedge clk);
    checks++; if (m_ack !== 4'b1000) begin errors++; $display("[TB] FAIL drop_ack got %b exp 1000", m_ack); end
    checks++; if (m_rd_data !== 32'h0000_CAFE) begin errors++; $display("[TB] FAIL drop_data got %h exp 0000cafe", m_rd_data); end
    @(negedge clk);
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL drop_idle got %b exp 0", busy); end
  endtask

  task automatic test_async_reset;
    m_rw[0]        = `READ;
    m_rw[1]        = `READ;
    tmr_rd_data    = 32'h0000_0055;
    m_req          = 4'b0010;
    @(negedge clk);
    checks++; if (tmr_cs !== 1'b1) begin errors++; $display("[TB] FAIL arst_pre_cs got %b exp 1", tmr_cs); end
    #2 rest = 1'b1;
    #1;
    checks++; if ({tmr_cs, tmr_as, busy} !== 3'b000) begin errors++; $display("[TB] FAIL arst_drop got %b exp 000", {tmr_cs, tmr_as, busy}); end
    checks++; if (m_ack !== 4'b0) begin errors++; $display("[TB] FAIL arst_ack got %b exp 0000", m_ack); end
    m_req = 4'b0011;
    @(negedge clk);
    checks++; if (m_ack !== 4'b0) begin errors++; $display("[TB] FAIL arst_ack_hold got %b exp 0000", m_ack); end
    rest = 1'b0;
    @(negedge clk);
    checks++; if (owner !== 2'd0 || tmr_cs !== 1'b1) begin errors++; $display("[TB] FAIL arst_regrant got owner %0d cs %b exp 0/1", owner, tmr_cs); end
    @(negedge clk);
    @(negedge clk);
    checks++; if (m_ack !== 4'b0001) begin errors++; $display("[TB] FAIL arst_ack0 got %b exp 0001", m_ack); end
    m_req = 4'b0;
    @(negedge clk);
  endtask

  task automatic test_round_robin;
    int n_ack;
    logic [3:0] exp_ack;
    do_reset();
    m_rw   = 4'b1111;
    tmr_rd_data = 32'h0000_0AAA;
    m_req  = 4'b1111;
    n_ack  = 0;
    for (int cyc = 0; cyc < 40 && n_ack < 5; cyc++) begin
      @(negedge clk);
      if (m_ack !== 4'b0) begin
        exp_ack = 4'b0001 << (n_ack % 4);
        checks++; if (m_ack !== exp_ack) begin errors++; $display("[TB] FAIL rr_ack%0d got %b exp %b", n_ack, m_ack, exp_ack); end
        n_ack++;
      end
    end
    checks++; if (n_ack != 5) begin errors++; $display("[TB] FAIL rr_count got %0d exp 5", n_ack); end
    m_req = 4'b0;
    @(negedge clk);
    @(negedge clk);
  endtask

`ifdef TIMER_ARB_TIMEOUT_EN
  task automatic test_timeout;
    int cs_cnt;
    bit got;
    do_reset();
    timer_en    = 1'b1;
    tmr_rd_data = 32'h0000_0077;
    m_rw[0]     = `READ;
    m_req       = 4'b0001;
    got = 1'b0;
    for (int cyc = 0; cyc < 10 && !got; cyc++) begin
      @(negedge clk);
      if (m_ack !== 4'b0) got = 1'b1;
    end
    checks++; if (m_rd_data !== 32'h0000_0077) begin errors++; $display("[TB] FAIL to_pre_data got %h exp 77", m_rd_data); end
    m_req = 4'b0;
    @(negedge clk);
    timer_en = 1'b0;
    m_req    = 4'b0001;
    cs_cnt   = 0;
    got      = 1'b0;
    for (int cyc = 0; cyc < 40 && !got; cyc++) begin
      @(negedge clk);
      if (tmr_cs === 1'b1) cs_cnt++;
      if (m_ack !== 4'b0) got = 1'b1;
    end
    checks++; if (!got) begin errors++; $display("[TB] FAIL to_wait got none exp ack"); end
    checks++; if (cs_cnt != 16) begin errors++; $display("[TB] FAIL to_cycles got %0d exp 16", cs_cnt); end
    checks++; if (m_ack !== 4'b0001 || m_err !== 4'b0001) begin errors++; $display("[TB] FAIL to_ack_err got %b/%b exp 0001/0001", m_ack, m_err); end
    checks++; if (m_rd_data !== 32'h0) begin errors++; $display("[TB] FAIL to_data got %h exp 0", m_rd_data); end
    m_req = 4'b0;
    @(negedge clk);
    checks++; if (busy !== 1'b0 || m_err !== 4'b0) begin errors++; $display("[TB] FAIL to_after got busy %b err %b exp 0/0000", busy, m_err); end
    timer_en = 1'b1;
  endtask
`endif

  initial begin
    checks      = 0;
    errors      = 0;
    timer_en    = 1'b1;
    rest        = 1'b1;
    m_req       = '0;
    m_rw        = '0;
    m_addr      = '0;
    m_wr_data   = '0;
    tmr_rd_data = '0;
    test_reset();
    test_single_read();
    test_write_stability();
    test_drop_request();
    test_async_reset();
    test_round_robin();
`ifdef TIMER_ARB_TIMEOUT_EN
    test_timeout();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
